// File: rtl/addsub_div_seq.sv
// addsub_div_seq: multi-cycle restoring divider (DIV/REM unit beside the ALU).
// One quotient bit per cycle through a single addsub instance wired as a
// subtractor. Handles signed and unsigned operands, and returns RISC-V M
// results for divide-by-zero and signed overflow.

// addsub: plain WIDTH-bit adder/subtractor, result modulo 2^WIDTH.
module addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_sub,
   output logic [WIDTH-1:0] result
);

   // Combinational add or subtract.
   always_comb begin
      result = is_sub ? (a - b) : (a + b);
   end

endmodule

module addsub_div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;

   // Working registers; only meaningful between an accept and the next FIXUP.
   logic [WIDTH-1:0]   rem_acc;
   logic [WIDTH-1:0]   quo_acc;
   logic [WIDTH-1:0]   dvs_mag;
   logic               sign_q;
   logic               sign_r;
   logic               dvs_zero;

   logic               accept;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH-1:0]   diff;
   logic               borrow;
   logic signed [WIDTH:0] trial;
   logic               trial_ge;

   // Two's-complement negation modulo 2^WIDTH (MIN maps to itself).
   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return '0 - x;
   endfunction

   // Magnitude of a possibly signed operand; |MIN| comes out as unsigned 2^(W-1).
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                  input logic           sgn);
      return (sgn && x[WIDTH-1]) ? negate(x) : x;
   endfunction

   assign accept = start & ready;

   // Partial remainder shifted left with the next dividend bit brought in.
   assign rem_shift = {rem_acc, quo_acc[WIDTH-1]};

   addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a      (rem_shift[WIDTH-1:0]),
      .b      (dvs_mag),
      .is_sub (1'b1),
      .result (diff)
   );

   // Trial bit WIDTH: borrow out of the low subtraction, folded with the top
   // bit of the shifted remainder (the divisor has no bit WIDTH).
   always_comb begin
      borrow = (~rem_shift[WIDTH-1] & dvs_mag[WIDTH-1])
             | (~(rem_shift[WIDTH-1] ^ dvs_mag[WIDTH-1]) & diff[WIDTH-1]);
      trial    = {rem_shift[WIDTH] ^ borrow, diff};
      trial_ge = (trial >= 0);
   end

   // Datapath: latch operands on accept, one restoring step per CALC cycle.
   always_ff @(posedge CLK) begin
      if (accept) begin
         sign_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         sign_r   <= is_signed & dividend[WIDTH-1];
         dvs_mag  <= magnitude(divisor, is_signed);
         dvs_zero <= (divisor == '0);
         rem_acc  <= '0;
         // On divide-by-zero the raw dividend is parked here for the remainder.
         quo_acc  <= (divisor == '0) ? dividend : magnitude(dividend, is_signed);
      end else if (state == CALC) begin
         rem_acc  <= trial_ge ? diff : rem_shift[WIDTH-1:0];
         quo_acc  <= {quo_acc[WIDTH-2:0], trial_ge};
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         count       <= '0;
         ready       <= 1'b1;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ready       <= 1'b0;
                  div_by_zero <= 1'b0;
                  if (divisor == '0) begin
                     state <= FIXUP;
                  end else begin
                     count <= CNT_W'(WIDTH);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state <= FIXUP;
               end
            end
            FIXUP: begin
               if (dvs_zero) begin
                  quotient    <= '1;
                  remainder   <= quo_acc;
                  div_by_zero <= 1'b1;
               end else begin
                  quotient    <= sign_q ? negate(quo_acc) : quo_acc;
                  remainder   <= sign_r ? negate(rem_acc) : rem_acc;
                  div_by_zero <= 1'b0;
               end
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_div_seq.sv
// Self-checking bench for addsub_div_seq: table of directed divides, a few
// random divides against a behavioural model, and hand-written sequences for
// start-while-busy and reset-abort.
module tb_addsub_div_seq;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          is_signed;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          ready;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;

   addsub_div_seq #(.WIDTH(W)) dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         sg;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   int   accept_cyc;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Behavioural reference with RISC-V M divide-by-zero and overflow rules.
   function automatic exp_t ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.dbz = 1'b0;
      e.lat = W + 2;
      if (b == 0) begin
         e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 2;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = a; e.r = '0;
      end else if (sg) begin
         e.q = $signed(a) / $signed(b);
         e.r = $signed(a) % $signed(b);
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   // Drive one request through its accept edge and queue what it must produce.
   task automatic issue(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e);
      int n = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("ready_before_issue", ready, 1'b1);
      is_signed = sg; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      accept_cyc = cyc;
      start = 1'b0;
      chk("ready_low_after_accept", ready, 1'b0);
      sb.push_back(e);
   endtask

   // Wait (bounded) for done, then pop the scoreboard and compare.
   task automatic collect(input string tag);
      int   n = 0;
      exp_t e;
      while (done !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL %s_timeout: got no done after %0d cycles, expected done", tag, n);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s_unexpected_done: got done, expected none queued", tag);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_dbz"}, W'(div_by_zero), W'(e.dbz));
      // Latency counts edges from the accept edge inclusive.
      chk({tag, "_lat"}, W'(cyc - accept_cyc + 1), W'(e.lat));
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, W'(done), 0);
      chk({tag, "_ready_back"}, W'(ready), 1);
   endtask

   vec_t vecs[13];
   exp_t e;
   int   d0;

   initial begin
      vecs[0]  = '{1'b0, 32'd1000,       32'd312,        32'd3,          32'd64,         1'b0};
      vecs[1]  = '{1'b1, 32'hFFFF_FC18,  32'd312,        32'hFFFF_FFFD,  32'hFFFF_FFC0,  1'b0};
      vecs[2]  = '{1'b0, 32'd1000,       32'd0,          32'hFFFF_FFFF,  32'd1000,       1'b1};
      vecs[3]  = '{1'b1, 32'd1000,       32'd0,          32'hFFFF_FFFF,  32'd1000,       1'b1};
      vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
      vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[6]  = '{1'b1, 32'd1000,       32'hFFFF_FEC8,  32'hFFFF_FFFD,  32'd64,         1'b0};
      vecs[7]  = '{1'b1, 32'hFFFF_FC18,  32'hFFFF_FEC8,  32'd3,          32'hFFFF_FFC0,  1'b0};
      vecs[8]  = '{1'b0, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
      vecs[9]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
      vecs[10] = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5,          1'b0};
      vecs[11] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
      vecs[12] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};

      start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", W'(ready), 1);
      chk("rst_done", W'(done), 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dbz", W'(div_by_zero), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 13; i++) begin
         e.q = vecs[i].q; e.r = vecs[i].r; e.dbz = vecs[i].dbz;
         e.lat = (vecs[i].b == 0) ? 2 : W + 2;
         issue(vecs[i].sg, vecs[i].a, vecs[i].b, e);
         collect($sformatf("vec%0d", i));
      end

      // Random operands against the model
      for (int i = 0; i < 8; i++) begin
         logic         sg;
         logic [W-1:0] a, b;
         sg = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = $urandom >> $urandom_range(0, 31);
         issue(sg, a, b, ref_div(sg, a, b));
         collect($sformatf("rnd%0d", i));
      end

      // start with new operands while busy is ignored
      issue(1'b0, 32'd1000, 32'd312, ref_div(1'b0, 32'd1000, 32'd312));
      repeat (5) begin @(posedge clk); #1; end
      is_signed = 1'b1; dividend = 32'h55; divisor = 32'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_ready_low", W'(ready), 0);
      collect("busy");
      d0 = done_cnt;
      repeat (6) begin @(posedge clk); #1; end
      chk("busy_no_extra_done", W'(done_cnt), W'(d0));

      // Reset during CALC aborts with no done pulse
      issue(1'b0, 32'h1234_5678, 32'd3, ref_div(1'b0, 32'h1234_5678, 32'd3));
      repeat (9) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("abort_ready", W'(ready), 1);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      chk("abort_done", W'(done), 0);
      sb.delete();
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin @(posedge clk); #1; end
      chk("abort_no_done", W'(done_cnt), W'(d0));
      issue(1'b0, 32'd7, 32'd2, ref_div(1'b0, 32'd7, 32'd2));
      collect("after_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
